// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode hand-off and redirect.
interface fetch_unit_if #(
    parameter int unsigned N = 64
) ();
    localparam int unsigned INSTR_W = 32;

    logic               br_taken;
    logic [N-1:0]       br_target;
    logic               imem_req;
    logic [N-1:0]       imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [N-1:0]       instr_pc;
    logic               decode_ready;

    // Fetch unit side
    modport master (
        input  br_taken, br_target, imem_ready, imem_rvalid, imem_rdata, decode_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    // Environment side (memory, decode, execute)
    modport slave (
        output br_taken, br_target, imem_ready, imem_rvalid, imem_rdata, decode_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch: PC register, in-order imem requests, 2-entry instruction queue,
// redirect with flush and stale-response discard.
module fetch_unit #(
    parameter int unsigned   N        = 64,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 2;
    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);
    localparam logic [N-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [N-1:0]       pc;
    } entry_t;

    logic [N-1:0]     pc_q, pc_d;
    logic [N-1:0]     resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    entry_t           q0_q, q0_d;
    entry_t           q1_q, q1_d;

    logic             pop;
    logic             req;
    logic             accept;
    logic             drop;
    logic             push;
    logic [2:0]       credit;
    logic [N-1:0]     target;
    entry_t           new_entry;

    // Issue/accept/response decode; request credit counts queued plus in-flight words
    always_comb begin
        pop            = valid_q && bus.decode_ready && !bus.br_taken;
        credit         = 3'(count_q) - 3'(pop) + 3'(outstanding_q);
        req            = !reset && !bus.br_taken && (credit < 3'd2);
        accept         = req && bus.imem_ready;
        drop           = bus.imem_rvalid && ((discard_q != '0) || bus.br_taken);
        push           = bus.imem_rvalid && !drop;
        target         = bus.br_target & ALIGN_MASK;
        new_entry.instr = bus.imem_rdata;
        new_entry.pc    = resp_pc_q;
    end

    // Next-state for PCs, in-flight/discard counters and the queue
    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(bus.imem_rvalid);
        discard_d     = discard_q;
        count_d       = count_q;
        q0_d          = q0_q;
        q1_d          = q1_q;

        if (bus.br_taken) begin
            pc_d      = target;
            resp_pc_d = target;
            // Every word still in flight (already-stale ones included) is now stale
            discard_d = outstanding_q - CNT_W'(bus.imem_rvalid);
            count_d   = '0;
        end else begin
            if (accept) begin
                pc_d = pc_q + N'(4);
            end
            if (bus.imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + N'(4);
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == '0) begin
                        q0_d = new_entry;
                    end else begin
                        q1_d = new_entry;
                    end
                    count_d = count_q + CNT_W'(1);
                end
                2'b01: begin
                    q0_d    = q1_q;
                    count_d = count_q - CNT_W'(1);
                end
                2'b11: begin
                    if (count_q == CNT_W'(1)) begin
                        q0_d = new_entry;
                    end else begin
                        q0_d = q1_q;
                        q1_d = new_entry;
                    end
                end
                default: ;
            endcase
        end

        valid_d = (count_d != '0);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= PC_INIT;
            resp_pc_q     <= PC_INIT;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
            q0_q          <= '0;
            q1_q          <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            valid_q       <= valid_d;
            q0_q          <= q0_d;
            q1_q          <= q1_d;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = q0_q.instr;
    assign bus.instr_pc    = q0_q.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, memory stall, backpressure,
// reset mid-operation and redirect with two words in flight.
module tb_fetch_unit;
    localparam int unsigned N = 64;

    logic clk = 1'b0;
    logic reset;
    logic hold;
    int   checks = 0;
    int   errors = 0;

    logic [N-1:0]  pend[$];
    logic [N-1:0]  log_pc[$];
    logic [31:0]   log_ins[$];
    int            n_before;
    logic [N-1:0]  p0, p1;
    logic [31:0]   i0, i1;

    fetch_unit_if #(.N(N)) bus ();

    fetch_unit #(.N(N), .RESET_PC(64'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // In-order memory: word for an accepted address returns the next cycle unless held
    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            bus.imem_rvalid <= 1'b0;
            bus.imem_rdata  <= '0;
        end else begin
            if (bus.imem_req && bus.imem_ready) pend.push_back(bus.imem_addr);
            if (!hold && pend.size() > 0) begin
                bus.imem_rvalid <= 1'b1;
                bus.imem_rdata  <= 32'(pend.pop_front() >> 2);
            end else begin
                bus.imem_rvalid <= 1'b0;
            end
        end
    end

    // Record what decode consumes
    always @(negedge clk) begin
        if (reset) begin
            log_pc.delete();
            log_ins.delete();
        end else if (bus.instr_valid && bus.decode_ready && !bus.br_taken) begin
            log_pc.push_back(bus.instr_pc);
            log_ins.push_back(bus.instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset            = 1'b1;
        hold             = 1'b0;
        bus.br_taken     = 1'b0;
        bus.br_target    = '0;
        bus.imem_ready   = 1'b1;
        bus.decode_ready = 1'b1;

        // Reset held three cycles
        repeat (3) begin
            tick();
            chk("rst_req", bus.imem_req, 0);
            chk("rst_valid", bus.instr_valid, 0);
        end
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_addr", bus.imem_addr, 0);

        // First cycle after release
        reset = 1'b0;
        settle();
        chk("first_req", bus.imem_req, 1);
        chk("first_addr", bus.imem_addr, 0);

        // Streaming startup: first instruction two cycles later
        tick();
        tick();
        chk("stream0_valid", bus.instr_valid, 1);
        chk("stream0_pc", bus.instr_pc, 0);
        chk("stream0_instr", bus.instr, 0);
        tick();
        chk("stream1_valid", bus.instr_valid, 1);
        chk("stream1_pc", bus.instr_pc, 4);
        chk("stream1_instr", bus.instr, 1);

        // Memory stall at 0x10
        tick();
        chk("stall_addr_pre", bus.imem_addr, 64'h10);
        bus.imem_ready = 1'b0;
        repeat (4) begin
            settle();
            chk("stall_req", bus.imem_req, 1);
            chk("stall_addr", bus.imem_addr, 64'h10);
            tick();
        end
        bus.imem_ready = 1'b1;
        settle();
        chk("stall_rel_req", bus.imem_req, 1);
        chk("stall_rel_addr", bus.imem_addr, 64'h10);
        tick();
        chk("stall_next_addr", bus.imem_addr, 64'h14);

        repeat (4) tick();

        // Decode backpressure: queue fills, requests stop, nothing consumed
        bus.decode_ready = 1'b0;
        n_before = log_pc.size();
        repeat (5) tick();
        settle();
        chk("bp_valid", bus.instr_valid, 1);
        chk("bp_req", bus.imem_req, 0);
        chk("bp_no_pop", 64'(log_pc.size()), 64'(n_before));

        bus.decode_ready = 1'b1;
        repeat (6) tick();

        // Everything consumed so far must be the contiguous stream (4i, i)
        chk("log_len", 64'(log_pc.size() > 8), 1);
        for (int i = 0; i < log_pc.size(); i++) begin
            chk("log_pc", log_pc[i], 64'(4 * i));
            chk("log_instr", 64'(log_ins[i]), 64'(i));
        end

        // Build a non-empty queue with one word in flight, then reset
        bus.decode_ready = 1'b0;
        repeat (3) tick();
        hold = 1'b1;
        bus.decode_ready = 1'b1;
        tick();
        bus.decode_ready = 1'b0;
        settle();
        chk("pre_rst_valid", bus.instr_valid, 1);
        chk("pre_rst_req", bus.imem_req, 0);

        reset = 1'b1;
        hold = 1'b0;
        bus.decode_ready = 1'b1;
        tick();
        chk("mid_rst_valid", bus.instr_valid, 0);
        chk("mid_rst_instr", bus.instr, 0);
        chk("mid_rst_instr_pc", bus.instr_pc, 0);
        chk("mid_rst_addr", bus.imem_addr, 0);
        chk("mid_rst_req", bus.imem_req, 0);

        // Redirect with two requests in flight (responses held)
        reset = 1'b0;
        hold = 1'b1;
        settle();
        chk("re_req0", bus.imem_req, 1);
        chk("re_addr0", bus.imem_addr, 0);
        tick();
        chk("re_addr1", bus.imem_addr, 4);
        tick();
        chk("re_full_req", bus.imem_req, 0);
        bus.br_taken  = 1'b1;
        bus.br_target = 64'h103;
        settle();
        chk("re_br_req", bus.imem_req, 0);
        tick();
        bus.br_taken = 1'b0;
        hold = 1'b0;
        settle();
        chk("re_target_addr", bus.imem_addr, 64'h100);
        chk("re_flush_valid", bus.instr_valid, 0);
        repeat (6) tick();
        chk("re_log_len", 64'(log_pc.size() >= 2), 1);
        p0 = (log_pc.size() > 0) ? log_pc[0] : '1;
        i0 = (log_ins.size() > 0) ? log_ins[0] : '1;
        p1 = (log_pc.size() > 1) ? log_pc[1] : '1;
        i1 = (log_ins.size() > 1) ? log_ins[1] : '1;
        chk("re_pc0", p0, 64'h100);
        chk("re_instr0", 64'(i0), 64'h40);
        chk("re_pc1", p1, 64'h104);
        chk("re_instr1", 64'(i1), 64'h41);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
